// File: rtl/tree_loader_ctrl.sv
// tree_loader_ctrl: feeds a 5x5 image row by row into a tree classifier.
// Each row is held on ui_out for HOLD_CYCLES clocks. After the last row,
// the controller waits SETTLE_CYCLES clocks for the classifier to settle.
// It then captures result_in and pulses done for one cycle.
module tree_loader_ctrl #(
  parameter int HOLD_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [24:0] img_in,
  input  logic [7:0]  result_in,
  output logic [7:0]  ui_out,
  output logic        busy,
  output logic        done,
  output logic [7:0]  result,
  output logic        result_valid
);

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DONE} state_t;

  // Terminal counts are compared against 8-bit counters, so a legal
  // parameter (1..255) can never make a counter wrap.
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_ROW    = 8'd5;

  state_t      state, next_state;
  logic [24:0] img_reg, next_img;
  logic [7:0]  row, next_row;
  logic [7:0]  cnt, next_cnt;
  logic [7:0]  next_result;
  logic        next_valid;
  logic [4:0]  row_bits;

  // State and datapath registers; a synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      img_reg      <= '0;
      row          <= '0;
      cnt          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= next_state;
      img_reg      <= next_img;
      row          <= next_row;
      cnt          <= next_cnt;
      result       <= next_result;
      result_valid <= next_valid;
    end
  end

  // Next-state logic. In every state, abort takes priority over start.
  always_comb begin
    next_state  = state;
    next_img    = img_reg;
    next_row    = row;
    next_cnt    = cnt;
    next_result = result;
    next_valid  = result_valid;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          next_state = LOAD;
          next_img   = img_in;
          next_row   = 8'd1;
          next_cnt   = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          next_state = IDLE;
          next_row   = '0;
          next_cnt   = '0;
        end else if (cnt == HOLD_LAST) begin
          next_cnt = '0;
          if (row == LAST_ROW) begin
            next_state = SETTLE;
            next_row   = '0;
          end else begin
            next_row = row + 8'd1;
          end
        end else begin
          next_cnt = cnt + 8'd1;
        end
      end
      SETTLE: begin
        if (abort) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else if (cnt == SETTLE_LAST) begin
          next_state  = DONE;
          next_cnt    = '0;
          next_result = result_in;
          next_valid  = 1'b1;
        end else begin
          next_cnt = cnt + 8'd1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs depend only on registered state. Row r maps to img_reg[5r-1:5r-5].
  always_comb begin
    row_bits = 5'd0;
    case (row)
      8'd1:    row_bits = img_reg[4:0];
      8'd2:    row_bits = img_reg[9:5];
      8'd3:    row_bits = img_reg[14:10];
      8'd4:    row_bits = img_reg[19:15];
      8'd5:    row_bits = img_reg[24:20];
      default: row_bits = 5'd0;
    endcase
    ui_out = (state == LOAD) ? {row_bits, row[2:0]} : 8'h00;
    busy   = (state == LOAD) || (state == SETTLE);
    done   = (state == DONE);
  end

endmodule

// File: tb/tb_tree_loader_ctrl.sv
// Self-checking bench for tree_loader_ctrl. It drives two instances.
// The main instance uses HOLD=2 and SETTLE=3 and runs a vector table plus
// hand-written sequences. The second instance uses HOLD=1 and SETTLE=2 and
// checks the single-cycle row sequence.
module tb_tree_loader_ctrl;

  localparam logic [24:0] IMG_A    = {5'h10, 5'h08, 5'h04, 5'h02, 5'h01};
  localparam logic [24:0] IMG_B    = 25'h0AAAAAA;
  localparam logic [24:0] IMG_ONES = 25'h1FFFFFF;
  localparam int          NVEC     = 23;

  typedef struct {
    logic        start;
    logic        abort;
    logic [24:0] img;
    logic [7:0]  res_in;
    logic [7:0]  exp_ui;
    logic        exp_busy;
    logic        exp_done;
    logic [7:0]  exp_result;
    logic        exp_valid;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, abort, start1;
  logic [24:0] img_in;
  logic [7:0]  result_in;
  logic [7:0]  ui_out, result, ui_out1, result1;
  logic        busy, done, result_valid, busy1, done1, result_valid1;

  int checks = 0;
  int errors = 0;
  vec_t vecs[NVEC];
  logic [7:0] seq1[7];
  int phase;

  always #5 clk = ~clk;

  tree_loader_ctrl #(.HOLD_CYCLES(2), .SETTLE_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .img_in(img_in),
    .result_in(result_in), .ui_out(ui_out), .busy(busy), .done(done),
    .result(result), .result_valid(result_valid)
  );

  tree_loader_ctrl #(.HOLD_CYCLES(1), .SETTLE_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .img_in(img_in),
    .result_in(result_in), .ui_out(ui_out1), .busy(busy1), .done(done1),
    .result(result1), .result_valid(result_valid1)
  );

  // Drive inputs on the falling edge, then wait until just after the next rising edge.
  task applyStimulus(input logic s, input logic a, input logic s1,
                     input logic [24:0] img, input logic [7:0] r);
    @(negedge clk);
    start     = s;
    abort     = a;
    start1    = s1;
    img_in    = img;
    result_in = r;
    @(posedge clk);
    #1;
  endtask

  task checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task checkMain(input string tag, input logic [7:0] eu, input logic eb,
                 input logic ed, input logic [7:0] er, input logic ev);
    checkOutput({tag, " ui_out"}, ui_out, eu);
    checkOutput({tag, " busy"}, {7'd0, busy}, {7'd0, eb});
    checkOutput({tag, " done"}, {7'd0, done}, {7'd0, ed});
    checkOutput({tag, " result"}, result, er);
    checkOutput({tag, " result_valid"}, {7'd0, result_valid}, {7'd0, ev});
  endtask

  initial begin
    // Main vector table: inputs applied before an edge, outputs expected after it.
    vecs[0]  = '{1'b1, 1'b0, IMG_A,    8'h3C, 8'h09, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, IMG_B,    8'h3C, 8'h09, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, IMG_B,    8'h3C, 8'h12, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, IMG_B,    8'h3C, 8'h12, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, IMG_B,    8'h3C, 8'h23, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, IMG_B,    8'h3C, 8'h23, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, IMG_B,    8'h3C, 8'h44, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, IMG_B,    8'h3C, 8'h44, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, IMG_B,    8'h3C, 8'h85, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, IMG_B,    8'h3C, 8'h85, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{1'b0, 1'b0, IMG_B,    8'h3C, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{1'b1, 1'b0, IMG_B,    8'h3C, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[12] = '{1'b0, 1'b0, IMG_B,    8'h3C, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[13] = '{1'b0, 1'b0, IMG_B,    8'hA5, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1};
    vecs[14] = '{1'b1, 1'b0, IMG_B,    8'h5A, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1};
    vecs[15] = '{1'b0, 1'b0, IMG_B,    8'h5A, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1};
    vecs[16] = '{1'b1, 1'b0, IMG_ONES, 8'h5A, 8'hF9, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[17] = '{1'b0, 1'b0, IMG_B,    8'h5A, 8'hF9, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[18] = '{1'b0, 1'b0, IMG_B,    8'h5A, 8'hFA, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[19] = '{1'b0, 1'b1, IMG_B,    8'h5A, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1};
    vecs[20] = '{1'b1, 1'b1, IMG_A,    8'h5A, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1};
    vecs[21] = '{1'b0, 1'b0, IMG_A,    8'h5A, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1};
    vecs[22] = '{1'b0, 1'b0, IMG_A,    8'h5A, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1};
    seq1[0] = 8'hF9; seq1[1] = 8'hFA; seq1[2] = 8'hFB; seq1[3] = 8'hFC;
    seq1[4] = 8'hFD; seq1[5] = 8'h00; seq1[6] = 8'h00;

    rst = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0;
    img_in = IMG_B; result_in = 8'h00;
    applyStimulus(1'b1, 1'b0, 1'b1, IMG_A, 8'hFF);
    applyStimulus(1'b1, 1'b0, 1'b1, IMG_A, 8'hFF);
    checkMain("reset", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("reset dut1 busy", {7'd0, busy1}, 8'h00);
    rst = 1'b0;

    $display("[TB] running vector table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].start, vecs[i].abort, 1'b0, vecs[i].img, vecs[i].res_in);
      checkMain($sformatf("vec%0d", i), vecs[i].exp_ui, vecs[i].exp_busy,
                vecs[i].exp_done, vecs[i].exp_result, vecs[i].exp_valid);
    end

    $display("[TB] HOLD=1 row sequence");
    applyStimulus(1'b0, 1'b0, 1'b1, IMG_ONES, 8'h11);
    checkOutput("h1 ui_out 0", ui_out1, seq1[0]);
    for (int i = 1; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, IMG_B, 8'h11);
      checkOutput($sformatf("h1 ui_out %0d", i), ui_out1, seq1[i]);
      checkOutput($sformatf("h1 busy %0d", i), {7'd0, busy1}, 8'h01);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, IMG_B, 8'hC3);
    checkOutput("h1 done", {7'd0, done1}, 8'h01);
    checkOutput("h1 result", result1, 8'hC3);
    checkOutput("h1 result_valid", {7'd0, result_valid1}, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b0, IMG_B, 8'h00);
    checkOutput("h1 done pulse", {7'd0, done1}, 8'h00);
    checkOutput("h1 result held", result1, 8'hC3);

    $display("[TB] reset during SETTLE and LOAD");
    applyStimulus(1'b1, 1'b0, 1'b0, IMG_A, 8'h00);
    for (int i = 1; i <= 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, IMG_A, 8'h00);
    checkMain("pre-rst settle", 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, IMG_A, 8'h99);
    checkMain("rst settle", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("rst dut1 result", result1, 8'h00);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, IMG_A, 8'h00);
    checkMain("post-rst start", 8'h09, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, IMG_A, 8'h00);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, IMG_A, 8'h00);
    checkMain("rst load", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;

    $display("[TB] start held high");
    for (int k = 0; k < 45; k++) begin
      applyStimulus(k < 40, 1'b0, 1'b0, IMG_A, 8'h77);
      phase = k % 15;
      checkOutput($sformatf("held busy k%0d", k), {7'd0, busy}, {7'd0, phase <= 12});
      checkOutput($sformatf("held done k%0d", k), {7'd0, done}, {7'd0, phase == 13});
    end
    checkMain("held end", 8'h00, 1'b0, 1'b0, 8'h77, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
